// File: rtl/cnt_mod.sv
// cnt_mod: parametrised up/down modulo counter with synchronous load.
// Counts 0..MAX_VAL, clamps out-of-range loads to MAX_VAL, flags the
// terminal count combinationally (tc) and emits a registered one-cycle
// wrap pulse after each boundary event.
// Build option: define CNT_MOD_SATURATE_EN to hold at the boundary instead
// of wrapping (wrap is then never asserted).
module cnt_mod #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             at_max;
  logic             at_zero;
  logic             boundary;

  assign at_max  = (count_reg == MAX_VAL);
  assign at_zero = (count_reg == '0);

  // Terminal count: high on the cycle whose edge would cross a boundary.
  assign tc = en & ((up & at_max) | (~up & at_zero));

  // A boundary event only happens when counting, never on a load cycle.
  assign boundary = tc & ~load;

  // Next-state selection: load beats counting; no inputs means hold.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (count_in > MAX_VAL) ? MAX_VAL : count_in;
    end else if (en) begin
      if (boundary) begin
`ifdef CNT_MOD_SATURATE_EN
        count_next = count_reg;
`else
        count_next = up ? '0 : MAX_VAL;
        wrap_next  = 1'b1;
`endif
      end else if (up) begin
        count_next = count_reg + ONE;
      end else begin
        count_next = count_reg - ONE;
      end
    end
  end

  // State registers; reset clears the count and drops any pending wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_cnt_mod.sv
// tb_cnt_mod: table-driven check of cnt_mod (WIDTH=4, MAX_VAL=9).
// Each vector is applied for one clock edge; the expected result is pushed
// to a scoreboard queue when driven and popped once the edge has happened.
// tc is sampled before the edge (it reflects the inputs and the old count);
// count and wrap are sampled after the edge.
module tb_cnt_mod;

  localparam int unsigned      W   = 4;
  localparam logic [W-1:0]     MXV = 4'd9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] count_in;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;

  cnt_mod #(.WIDTH(W), .MAX_VAL(MXV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .count_in (count_in),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] cin;
    logic [W-1:0] exp_count;
    logic         exp_tc;
    logic         exp_wrap;
  } vec_t;

  typedef struct {
    int           idx;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic e, input logic u,
                     input logic l, input int ci, input int ec,
                     input logic et, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l;
    v.cin = W'(ci); v.exp_count = W'(ec); v.exp_tc = et; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL vec%0d %s: got %0d want %0d", idx, name, got, want);
  endtask

  initial begin
    logic tc_seen;
    exp_t e;
    int   wraps;

    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; count_in = '0;

    // ---- reset ----
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
`ifndef CNT_MOD_SATURATE_EN
    // ---- up wrap: 1..9, 0, 1, 2 ----
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, i, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 2, 0, 0);
    // ---- down wrap from 2: 1, 0, 9, 8 ----
    add(0, 0, 0, 1, 2, 2, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 9, 1, 1);
    add(0, 1, 0, 0, 0, 8, 0, 0);
    // ---- load priority, clamp, load at boundary, reset beats load ----
    add(0, 1, 1, 1, 5, 5, 0, 0);
    add(0, 1, 1, 1, 14, 9, 0, 0);
    add(0, 1, 1, 1, 3, 3, 1, 0);
    add(1, 1, 1, 1, 7, 0, 0, 0);
    add(0, 0, 0, 1, 15, 9, 0, 0);
    // ---- reset at a boundary suppresses the wrap pulse ----
    add(1, 1, 1, 0, 0, 0, 1, 0);
    // ---- hold and direction change ----
    add(0, 0, 0, 1, 6, 6, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 6, 0, 0);
    add(0, 1, 1, 0, 0, 7, 0, 0);
    add(0, 1, 0, 0, 0, 6, 0, 0);
    add(0, 1, 1, 0, 0, 7, 0, 0);
    add(0, 1, 0, 0, 0, 6, 0, 0);
`else
    // ---- saturating build: up from 8, down from 1 ----
    add(0, 0, 0, 1, 8, 8, 0, 0);
    add(0, 1, 1, 0, 0, 9, 0, 0);
    add(0, 1, 1, 0, 0, 9, 1, 0);
    add(0, 1, 1, 0, 0, 9, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 14, 9, 0, 0);
    add(0, 1, 0, 0, 0, 8, 0, 0);
`endif

    // Idle cycles before the first reset: no checks, count is unknown.
    for (int i = 0; i < 4; i++) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
      load = vecs[i].load; count_in = vecs[i].cin;
      e.idx = i; e.count = vecs[i].exp_count;
      e.tc = vecs[i].exp_tc; e.wrap = vecs[i].exp_wrap;
      sb.push_back(e);
      #1 tc_seen = tc;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("count", e.idx, int'(count), int'(e.count));
      check("tc",    e.idx, int'(tc_seen), int'(e.tc));
      check("wrap",  e.idx, int'(wrap), int'(e.wrap));
      $display("vec%0d rst=%0b en=%0b up=%0b load=%0b cin=%0d -> count=%0d tc=%0b wrap=%0b",
               i, vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load,
               vecs[i].cin, count, tc_seen, wrap);
    end

    // Continuous up-count: wrap should pulse once every MAX_VAL+1 cycles.
    @(negedge clk);
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (wrap) wraps++;
    end
`ifndef CNT_MOD_SATURATE_EN
    check("wrap_period", 1000, wraps, 3);
`else
    check("wrap_period", 1000, wraps, 0);
`endif
    $display("run30 wraps=%0d count=%0d", wraps, count);
    en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
